// File: rtl/hamming_tx_ctrl.sv
// Hamming(12,8) serial transmit controller: byte handshake, AddParity encode, start/data/stop framing.
// Optional build macro HAMMING_ERR_INJECT_EN adds err_inject/err_pos for deliberate single-bit corruption.

module add_parity (
    input  logic [1:8]  data_in,
    output logic [1:12] code_out
);
    // Parity bits sit at the power-of-two positions; data fills the rest in order.
    assign code_out[3]  = data_in[1];
    assign code_out[5]  = data_in[2];
    assign code_out[6]  = data_in[3];
    assign code_out[7]  = data_in[4];
    assign code_out[9]  = data_in[5];
    assign code_out[10] = data_in[6];
    assign code_out[11] = data_in[7];
    assign code_out[12] = data_in[8];
    assign code_out[1]  = data_in[1] ^ data_in[2] ^ data_in[4] ^ data_in[5] ^ data_in[7];
    assign code_out[2]  = data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6] ^ data_in[7];
    assign code_out[4]  = data_in[2] ^ data_in[3] ^ data_in[4] ^ data_in[8];
    assign code_out[8]  = data_in[5] ^ data_in[6] ^ data_in[7] ^ data_in[8];
endmodule

module hamming_tx_ctrl #(
    parameter int BIT_CYCLES = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:8] in_data,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic       err_inject,
    input  logic [3:0] err_pos,
`endif
    output logic       tx_out,
    output logic       tx_busy,
    output logic       done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int SW = $clog2(STOP_BITS + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:8]    data_q, data_d;
    logic [1:12]   codeword_q, codeword_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    bit_q, bit_d;
    logic [SW-1:0] stop_q, stop_d;
    logic          tx_out_q, tx_out_d;
    logic          tx_busy_q, tx_busy_d;
    logic          done_q, done_d;
    logic [1:12]   enc_code;
    logic [1:12]   flip_mask;
    logic          accept;
    logic          cyc_wrap;

    add_parity u_add_parity (
        .data_in  (data_q),
        .code_out (enc_code)
    );

`ifdef HAMMING_ERR_INJECT_EN
    logic       err_inject_q, err_inject_d;
    logic [3:0] err_pos_q, err_pos_d;

    always_comb begin
        err_inject_d = err_inject_q;
        err_pos_d    = err_pos_q;
        if (accept) begin
            err_inject_d = err_inject;
            err_pos_d    = err_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_inject_q <= 1'b0;
            err_pos_q    <= 4'd0;
        end else begin
            err_inject_q <= err_inject_d;
            err_pos_q    <= err_pos_d;
        end
    end

    // Positions outside 1..12 match no mask bit, so they leave the codeword intact.
    for (genvar gi = 1; gi <= 12; gi++) begin : g_flip
        assign flip_mask[gi] = err_inject_q && (err_pos_q == 4'(gi));
    end
`else
    assign flip_mask = '0;
`endif

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign cyc_wrap = (cyc_q == CYC_LAST);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        codeword_d = codeword_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        stop_d     = stop_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                codeword_d = enc_code ^ flip_mask;
                cyc_d      = '0;
                state_d    = START;
            end
            START: begin
                if (cyc_wrap) begin
                    cyc_d   = '0;
                    bit_d   = 4'd1;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (cyc_wrap) begin
                    cyc_d = '0;
                    if (bit_q == 4'd12) begin
                        stop_d  = SW'(1);
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (cyc_wrap) begin
                    cyc_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line matches the state it enters.
    always_comb begin
        tx_out_d  = 1'b1;
        tx_busy_d = (state_d != IDLE);
        done_d    = (state_d == STOP) && (stop_d == STOP_LAST) && (cyc_d == CYC_LAST);
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = codeword_q[bit_d];
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            codeword_q <= '0;
            cyc_q      <= '0;
            bit_q      <= 4'd0;
            stop_q     <= '0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            codeword_q <= codeword_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Directed bench for hamming_tx_ctrl: one instance at 1 cycle/bit, 1 stop bit; one at 3 cycles/bit, 2 stop bits.

module tb_hamming_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel = 1'b0;
    logic       valid_a, valid_b;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;
    logic       rdy_s, tx_s, busy_s, done_s;
`ifdef HAMMING_ERR_INJECT_EN
    logic       err_inject = 1'b0;
    logic [3:0] err_pos = 4'd0;
`endif
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign valid_a = in_valid && !sel;
    assign valid_b = in_valid && sel;
    assign rdy_s   = sel ? rdy_b  : rdy_a;
    assign tx_s    = sel ? tx_b   : tx_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign done_s  = sel ? done_b : done_a;

    hamming_tx_ctrl #(.BIT_CYCLES(1), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (valid_a),
        .in_ready   (rdy_a),
        .in_data    (in_data),
`ifdef HAMMING_ERR_INJECT_EN
        .err_inject (err_inject),
        .err_pos    (err_pos),
`endif
        .tx_out     (tx_a),
        .tx_busy    (busy_a),
        .done       (done_a)
    );

    hamming_tx_ctrl #(.BIT_CYCLES(3), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (valid_b),
        .in_ready   (rdy_b),
        .in_data    (in_data),
`ifdef HAMMING_ERR_INJECT_EN
        .err_inject (err_inject),
        .err_pos    (err_pos),
`endif
        .tx_out     (tx_b),
        .tx_busy    (busy_b),
        .done       (done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake one byte on the selected instance and check every cycle of the resulting frame.
    // cw[11] is codeword position 1. With hold, in_valid stays high and in_data moves to next_d.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic [11:0] cw,
                              input int nb, input int ns, input bit hold, input logic [7:0] next_d);
        int  slot;
        int  last;
        logic exp_tx;
        last = (13 + ns) * nb - 1;
        check({tag, "_rdy_before"}, 32'(rdy_s), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        if (hold) in_data = next_d;
        else      in_valid = 1'b0;
        check({tag, "_load_tx"},   32'(tx_s),   32'd1);
        check({tag, "_load_busy"}, 32'(busy_s), 32'd1);
        check({tag, "_load_rdy"},  32'(rdy_s),  32'd0);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            slot = c / nb;
            if (slot == 0)       exp_tx = 1'b0;
            else if (slot <= 12) exp_tx = cw[12 - slot];
            else                 exp_tx = 1'b1;
            check($sformatf("%s_tx_c%0d", tag, c + 2),   32'(tx_s),   32'(exp_tx));
            check($sformatf("%s_done_c%0d", tag, c + 2), 32'(done_s), 32'(c == last));
            check($sformatf("%s_busy_c%0d", tag, c + 2), 32'(busy_s), 32'd1);
        end
        @(negedge clk);
        check({tag, "_end_rdy"},  32'(rdy_s),  32'd1);
        check({tag, "_end_busy"}, 32'(busy_s), 32'd0);
        check({tag, "_end_tx"},   32'(tx_s),   32'd1);
        check({tag, "_end_done"}, 32'(done_s), 32'd0);
        $display("frame %s data=%02h cw=%03h bit_cycles=%0d stop_bits=%0d checks=%0d failures=%0d",
                 tag, d, cw, nb, ns, n_checks, n_fail);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_a",   32'(tx_a),   32'd1);
        check("rst_rdy_a",  32'(rdy_a),  32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_tx_b",   32'(tx_b),   32'd1);
        check("rst_rdy_b",  32'(rdy_b),  32'd1);
        rst = 1'b0;
        @(negedge clk);

        sel = 1'b0;
        send_frame("zero",  8'h00,       12'b000000000000, 1, 1, 1'b0, 8'h00);
        send_frame("d1",    8'b10000000, 12'b111000000000, 1, 1, 1'b0, 8'h00);
        send_frame("ones",  8'hFF,       12'b111011101111, 1, 1, 1'b0, 8'h00);
        send_frame("d2",    8'b01000000, 12'b100110000000, 1, 1, 1'b0, 8'h00);

        // Reset while data bit 5 of an all-zero frame holds the line low.
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_pre_tx", 32'(tx_a), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx",   32'(tx_a),   32'd1);
        check("midrst_rdy",  32'(rdy_a),  32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        $display("midrst tx=%0d rdy=%0d busy=%0d", tx_a, rdy_a, busy_a);
        send_frame("post_rst", 8'b10000000, 12'b111000000000, 1, 1, 1'b0, 8'h00);

        // Back-to-back bytes with in_valid held high on the slow instance.
        sel = 1'b1;
        send_frame("hold1", 8'hFF,       12'b111011101111, 3, 2, 1'b1, 8'b01000000);
        send_frame("hold2", 8'b01000000, 12'b100110000000, 3, 2, 1'b0, 8'h00);
        sel = 1'b0;

`ifdef HAMMING_ERR_INJECT_EN
        err_inject = 1'b1;
        err_pos    = 4'd3;
        send_frame("inj3",  8'h00,       12'b001000000000, 1, 1, 1'b0, 8'h00);
        err_pos    = 4'd13;
        send_frame("inj13", 8'h00,       12'b000000000000, 1, 1, 1'b0, 8'h00);
        err_pos    = 4'd12;
        send_frame("inj12", 8'b10000000, 12'b111000000001, 1, 1, 1'b0, 8'h00);
        err_pos    = 4'd0;
        send_frame("inj0",  8'b10000000, 12'b111000000000, 1, 1, 1'b0, 8'h00);
        err_inject = 1'b0;
        err_pos    = 4'd1;
        send_frame("noinj", 8'hFF,       12'b111011101111, 1, 1, 1'b0, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
